// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit_if
//  Purpose  : Issue/result bundle between the execute-stage controller and the
//             iterative multiply/divide unit.
//  Ports    : start/op/a/b     - operation issue (op: 00 MULTU 01 MULT
//                                10 DIVU 11 DIV)
//             abort            - cancel a running operation
//             hi_we/lo_we/wdata- MTHI/MTLO writes
//             busy/done        - status (done is a one-cycle commit pulse)
//             hi/lo            - architectural HI/LO registers
//  Revision : 1.0  initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Controller side
    modport master (
        output start, op, a, b, abort, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    // Multiply/divide unit side
    modport slave (
        input  start, op, a, b, abort, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative signed/unsigned multiply and divide with architectural
//             HI/LO registers. Fixed latency of WIDTH+1 cycles per operation.
//  Ports    : clk    - rising-edge clock
//             reset  - asynchronous, active-low; clears all state
//             bus    - muldiv_unit_if.slave (issue, abort, MTHI/MTLO, status,
//                      HI/LO results)
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  wire logic    clk,
    input  wire logic    reset,
    muldiv_unit_if.slave bus
);

    localparam logic [1:0]       c_IDLE = 2'd0;
    localparam logic [1:0]       c_RUN  = 2'd1;
    localparam logic [1:0]       c_FIX  = 2'd2;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [1:0]         r_op;
    logic               r_sa;
    logic               r_sb;
    logic [WIDTH-1:0]   r_a;      // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0]   r_b;      // multiplier (shifted right), or divisor (held)
    logic [2*WIDTH-1:0] r_acc;    // product accumulator
    logic [WIDTH-1:0]   r_rem;    // partial remainder
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_busy;
    logic               w_accept;
    logic               w_step;
    logic               w_commit;
    logic               w_mt_ok;

    // ---------------------------------------------------------------- issue
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;

    assign w_sa    = bus.op[0] & bus.a[WIDTH-1];
    assign w_sb    = bus.op[0] & bus.b[WIDTH-1];
    assign w_abs_a = w_sa ? -bus.a : bus.a;
    assign w_abs_b = w_sb ? -bus.b : bus.b;

    // ---------------------------------------------------- multiply iteration
    logic [WIDTH-1:0]   w_maddend;
    logic [WIDTH:0]     w_msum;

    assign w_maddend = r_b[0] ? r_a : {WIDTH{1'b0}};
    assign w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_maddend};

    // ------------------------------------------------------ divide iteration
    // The trial remainder is one bit wider than the operands; after a
    // successful subtract the result is below the divisor, so the low WIDTH
    // bits of the modular difference are exact.
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;

    assign w_trial = {r_rem, r_a[WIDTH-1]};
    assign w_ge    = (w_trial >= {1'b0, r_b});
    assign w_sub   = w_trial[WIDTH-1:0] - r_b;

    // ------------------------------------------------------ sign correction
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_dz;

    assign w_prod = (r_op[0] && (r_sa ^ r_sb)) ? -r_acc : r_acc;
    assign w_quo  = (r_op[0] && (r_sa ^ r_sb)) ? -r_a   : r_a;
    // With a zero divisor every trial subtract succeeds, so the remainder
    // ends as |a| and the sign fix-up restores a exactly; only the quotient
    // needs overriding.
    assign w_rem  = (r_op[0] && r_sa) ? -r_rem : r_rem;
    assign w_dz   = (r_b == {WIDTH{1'b0}});

    // ------------------------------------------------------- state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: if (bus.start) w_next = c_RUN;
            c_RUN: begin
                if (bus.abort)            w_next = c_IDLE;
                else if (r_cnt == c_LAST) w_next = c_FIX;
            end
            c_FIX:   w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // --------------------------------------------------------- state decode
    always_comb begin
        w_busy   = 1'b0;
        w_accept = 1'b0;
        w_step   = 1'b0;
        w_commit = 1'b0;
        w_mt_ok  = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_accept = bus.start;
                w_mt_ok  = !bus.start;   // start wins over MTHI/MTLO
            end
            c_RUN: begin
                w_busy = 1'b1;
                w_step = !bus.abort;
            end
            c_FIX: begin
                w_busy   = 1'b1;
                w_commit = !bus.abort;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op   <= 2'b00;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_commit;

            if (w_accept) begin
                r_op  <= bus.op;
                r_sa  <= w_sa;
                r_sb  <= w_sb;
                r_a   <= w_abs_a;
                r_b   <= w_abs_b;
                r_acc <= '0;
                r_rem <= '0;
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_op[1]) begin
                    r_rem <= w_ge ? w_sub : w_trial[WIDTH-1:0];
                    r_a   <= {r_a[WIDTH-2:0], w_ge};
                end else begin
                    r_acc <= {w_msum, r_acc[WIDTH-1:1]};
                    r_b   <= r_b >> 1;
                end
            end

            if (w_commit) begin
                if (r_op[1]) begin
                    r_hi <= w_rem;
                    r_lo <= w_dz ? {WIDTH{1'b1}} : w_quo;
                end else begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end
            end else if (w_mt_ok) begin
                if (bus.hi_we) r_hi <= bus.wdata;
                if (bus.lo_we) r_lo <= bus.wdata;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Directed self-checking bench for muldiv_unit (WIDTH = 32).
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

    logic clk;
    logic reset;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;
    int d0     = 0;
    logic [31:0] m_hi = 32'h0;   // bench's own view of HI/LO
    logic [31:0] m_lo = 32'h0;

    always @(posedge clk) if (bus.done) n_done <= n_done + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait for done. poke: 0 none, 1 re-start during busy,
    // 2 MTHI/MTLO during busy. Returns in the done cycle.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int poke);
        int cyc;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        d0        = n_done;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        chk({tag, " busy@E0"}, bus.busy, 1'b1);
        cyc = 0;
        while (!bus.done && cyc < 60) begin
            if (cyc == 9 && poke == 1) begin
                bus.start = 1'b1;
                bus.op    = 2'b10;
            end
            if (cyc == 9 && poke == 2) begin
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
                bus.wdata = 32'hDEAD_BEEF;
            end
            tick();
            cyc++;
            bus.start = 1'b0;
            bus.hi_we = 1'b0;
            bus.lo_we = 1'b0;
            if (cyc == 10 && poke == 2) begin
                chk({tag, " hi held"}, bus.hi, m_hi);
                chk({tag, " lo held"}, bus.lo, m_lo);
            end
        end
        chk({tag, " latency"}, cyc, 33);
        chk({tag, " hi"}, bus.hi, eh);
        chk({tag, " lo"}, bus.lo, el);
        chk({tag, " busy@done"}, bus.busy, 1'b0);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic post_done(input string tag);
        tick();
        chk({tag, " done low"}, bus.done, 1'b0);
        chk({tag, " done count"}, n_done - d0, 1);
    endtask

    initial begin
        int dn;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.abort = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;

        tick();
        tick();
        chk("rst hi", bus.hi, 32'h0);
        chk("rst lo", bus.lo, 32'h0);
        chk("rst busy", bus.busy, 1'b0);
        chk("rst done", bus.done, 1'b0);
        reset = 1'b1;
        tick();

        // Back-to-back: second op issued in the done cycle of the first
        run_op("MULT -3*7", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("MULTU max*max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        post_done("MULTU max*max");

        run_op("MULTU 0*x", 2'b00, 32'h0, 32'h1234_5678, 32'h0, 32'h0, 1);
        post_done("MULTU 0*x");

        run_op("DIVU 100/7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 2);
        run_op("DIV -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("DIV 7/-2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0);
        run_op("DIVU 5/0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);
        run_op("DIV min/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);
        run_op("DIV -5/0", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
        post_done("DIV -5/0");

        // MTHI / MTLO in IDLE
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_1234;
        tick();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_5678;
        tick();
        bus.lo_we = 1'b0;
        chk("MTHI", bus.hi, 32'h0000_1234);
        chk("MTLO", bus.lo, 32'h0000_5678);

        // start together with MTHI: start wins, write dropped; then abort
        dn        = n_done;
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        bus.hi_we = 1'b1;
        bus.wdata = 32'hFFFF_0000;
        tick();
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        chk("start+MTHI busy", bus.busy, 1'b1);
        chk("start+MTHI hi", bus.hi, 32'h0000_1234);
        repeat (4) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort busy", bus.busy, 1'b0);
        chk("abort hi", bus.hi, 32'h0000_1234);
        chk("abort lo", bus.lo, 32'h0000_5678);
        repeat (40) tick();
        chk("abort no done", n_done - dn, 0);
        chk("abort hi later", bus.hi, 32'h0000_1234);

        // Asynchronous reset in the middle of an operation
        dn        = n_done;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'hFFFF_FFFF;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        #1;
        chk("midrst hi", bus.hi, 32'h0);
        chk("midrst lo", bus.lo, 32'h0);
        chk("midrst busy", bus.busy, 1'b0);
        chk("midrst done", bus.done, 1'b0);
        tick();
        reset = 1'b1;
        repeat (40) tick();
        chk("midrst no done", n_done - dn, 0);
        chk("midrst idle", bus.busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
